// File: rtl/cartoon_pkg.sv
// Shared types for the cartoon pipeline write path: write-master FSM states,
// byte-address type, default batch length and address step helper.
package cartoon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } wm_state_t;

    typedef logic [31:0] addr_t;

    localparam int BURST_LEN_DEF = 6;

    // Modulo-2^32 address step; wrap past 0xFFFFFFFC is intentionally silent
    function automatic addr_t next_addr(input addr_t addr, input int unsigned stride);
        return addr + addr_t'(stride);
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear; counts 0..rollover_val-1 and wraps,
// rollover_flag marks the final count of the period.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_r;

    assign rollover_flag = (count_r == (rollover_val - {{(NUM_CNT_BITS-1){1'b0}}, 1'b1}));
    assign count_out     = count_r;

    // Count register: clear wins over enable, wrap at end of period
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (count_enable) begin
            if (rollover_flag) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/write_master.sv
// Avalon-MM write master streaming batches of pixel words into a frame buffer.
// Optional response watchdog enabled by defining WRITE_MASTER_TIMEOUT_EN.
module write_master
    import cartoon_pkg::*;
#(
    parameter int          BURST_LEN      = BURST_LEN_DEF,
    parameter int unsigned ADDR_STRIDE    = 4,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] base_addr,
    input  logic [19:0] frame_len,
    input  logic        batch_ready,
    input  logic [31:0] pixel_word,
    input  logic        master_waitrequest,
    input  logic        master_writeresponsevalid,
    output logic        master_write,
    output logic [31:0] master_address,
    output logic [31:0] master_writedata,
    output logic        word_pop,
    output logic        batch_done,
    output logic        frame_done,
    output logic        busy,
    output logic        error
);

    wm_state_t   state_r, state_s;
    addr_t       addr_r, base_r;
    logic [19:0] frame_cnt_r;
    logic        pending_r, error_r, restart_r;
    logic [3:0]  word_cnt_s;
    logic        rollover_s, last_word_s;
    logic        go_s, resp_s, frame_wrap_s, timeout_s;

    assign go_s         = (state_r == IDLE) && (batch_ready || pending_r);
    assign resp_s       = (state_r == RESP) && master_writeresponsevalid;
    assign frame_wrap_s = resp_s && (frame_len != 20'd0) && (frame_cnt_r == (frame_len - 20'd1));
    // A count beyond the limit (upset) still closes the batch instead of running on
    assign last_word_s  = rollover_s || (word_cnt_s >= 4'(BURST_LEN - 1));

    flex_counter #(
        .NUM_CNT_BITS (4)
    ) u_word_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (state_r == IDLE),
        .count_enable  (resp_s),
        .rollover_val  (4'(BURST_LEN)),
        .count_out     (word_cnt_s),
        .rollover_flag (rollover_s)
    );

`ifdef WRITE_MASTER_TIMEOUT_EN
    logic [15:0] tmo_cnt_r;

    assign timeout_s = (state_r == RESP) && !master_writeresponsevalid &&
                       (tmo_cnt_r == 16'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts RESP cycles spent waiting for the write response
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tmo_cnt_r <= 16'd0;
        end else if ((state_r == RESP) && !resp_s) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end else begin
            tmo_cnt_r <= 16'd0;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (go_s) state_s = WRITE;
                else      state_s = IDLE;
            end
            WRITE: begin
                if (!master_waitrequest) state_s = RESP;
                else                     state_s = WRITE;
            end
            RESP: begin
                if (resp_s) begin
                    if (last_word_s) state_s = IDLE;
                    else             state_s = WRITE;
                end else if (timeout_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Address, latched base, frame position and pending frame restart
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_r      <= 32'd0;
            base_r      <= 32'd0;
            frame_cnt_r <= 20'd0;
            restart_r   <= 1'b1;
        end else if (go_s) begin
            base_r <= base_addr;
            if (restart_r) begin
                addr_r    <= base_addr;
                restart_r <= 1'b0;
            end
        end else if (resp_s) begin
            if (frame_wrap_s) begin
                addr_r      <= base_r;
                frame_cnt_r <= 20'd0;
                restart_r   <= last_word_s;
            end else begin
                addr_r      <= next_addr(addr_r, ADDR_STRIDE);
                frame_cnt_r <= frame_cnt_r + 20'd1;
            end
        end
    end

    // One-deep batch queue and sticky error
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pending_r <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            if (go_s) begin
                pending_r <= pending_r && batch_ready;
            end else if (batch_ready && (state_r != IDLE)) begin
                if (pending_r) error_r   <= 1'b1;
                else           pending_r <= 1'b1;
            end
            if (timeout_s) error_r <= 1'b1;
        end
    end

    assign master_write     = (state_r == WRITE);
    assign master_address   = addr_r;
    assign master_writedata = pixel_word;
    assign word_pop         = resp_s;
    assign batch_done       = resp_s && last_word_s;
    assign frame_done       = frame_wrap_s;
    assign busy             = (state_r != IDLE);
    assign error            = error_r;

endmodule

// File: tb/tb_write_master.sv
// Directed bench for write_master: bench acts as Avalon slave and pixel buffer,
// expected write addresses/data/pulses come from a scoreboard queue.
module tb_write_master;

    localparam int BL = 6;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        bd;
        logic        fd;
    } wm_exp_t;

    logic        clk;
    logic        n_rst;
    logic [31:0] base_addr;
    logic [19:0] frame_len;
    logic        batch_ready;
    logic [31:0] pixel_word;
    logic        master_waitrequest;
    logic        master_writeresponsevalid;
    logic        master_write;
    logic [31:0] master_address;
    logic [31:0] master_writedata;
    logic        word_pop;
    logic        batch_done;
    logic        frame_done;
    logic        busy;
    logic        error;

    wm_exp_t     sb[$];
    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          pix_idx = 0;
    int          m_pix   = 0;
    int          m_frame = 0;
    logic [31:0] m_addr;
    logic [31:0] m_base;
    logic        exp_err;

    write_master #(
        .BURST_LEN      (BL),
        .ADDR_STRIDE    (4),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk                       (clk),
        .n_rst                     (n_rst),
        .base_addr                 (base_addr),
        .frame_len                 (frame_len),
        .batch_ready               (batch_ready),
        .pixel_word                (pixel_word),
        .master_waitrequest        (master_waitrequest),
        .master_writeresponsevalid (master_writeresponsevalid),
        .master_write              (master_write),
        .master_address            (master_address),
        .master_writedata          (master_writedata),
        .word_pop                  (word_pop),
        .batch_done                (batch_done),
        .frame_done                (frame_done),
        .busy                      (busy),
        .error                     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Upstream pixel buffer: word n carries a recognisable pattern
    task automatic set_pixel();
        pixel_word = 32'hC0DE_0000 + 32'(pix_idx);
    endtask

    // Reference model: expected writes for one batch
    task automatic push_batch();
        wm_exp_t e;
        for (int i = 0; i < BL; i++) begin
            e.addr = m_addr;
            e.data = 32'hC0DE_0000 + 32'(m_pix);
            e.bd   = (i == BL - 1);
            e.fd   = (frame_len != 20'd0) && (m_frame == int'(frame_len) - 1);
            sb.push_back(e);
            m_pix++;
            if (e.fd) begin
                m_frame = 0;
                m_addr  = m_base;
            end else begin
                m_frame++;
                m_addr = m_addr + 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        n_rst                     = 1'b0;
        batch_ready               = 1'b0;
        master_waitrequest        = 1'b1;
        master_writeresponsevalid = 1'b0;
        #1;
        chk1("rst_write", master_write, 1'b0);
        chk32("rst_addr", master_address, 32'd0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_error", error, 1'b0);
        chk1("rst_pulses", word_pop | batch_done | frame_done, 1'b0);
        tick();
        tick();
        n_rst = 1'b1;
        sb.delete();
        m_base  = base_addr;
        m_addr  = base_addr;
        m_frame = 0;
        m_pix   = pix_idx;
        exp_err = 1'b0;
    endtask

    task automatic pulse_ready(input logic expect_batch);
        batch_ready = 1'b1;
        if (expect_batch) push_batch();
        tick();
        batch_ready = 1'b0;
    endtask

    // Serve one write: mode 0 respond, 1 reset while in RESP, 2 never respond
    task automatic serve_word(input int stall, input int mode);
        wm_exp_t e;
        int n;
        n = 0;
        while (master_write !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk1("write_seen", master_write, 1'b1);
        if (sb.size() == 0) begin
            chk1("sb_nonempty", 1'b0, 1'b1);
            return;
        end
        e = sb.pop_front();
        chk32("addr", master_address, e.addr);
        chk32("wdata", master_writedata, e.data);
        for (int k = 0; k < stall; k++) begin
            master_writeresponsevalid = 1'b1;
            tick();
            chk1("stall_write", master_write, 1'b1);
            chk32("stall_addr", master_address, e.addr);
            chk32("stall_wdata", master_writedata, e.data);
            chk1("stray_resp_pop", word_pop, 1'b0);
        end
        master_writeresponsevalid = 1'b0;
        master_waitrequest        = 1'b0;
        tick();
        master_waitrequest = 1'b1;
        chk1("resp_write_low", master_write, 1'b0);
        chk1("resp_no_pop", word_pop, 1'b0);
        if (mode == 0) begin
            master_writeresponsevalid = 1'b1;
            #1;
            chk1("word_pop", word_pop, 1'b1);
            chk1("batch_done", batch_done, e.bd);
            chk1("frame_done", frame_done, e.fd);
            tick();
            master_writeresponsevalid = 1'b0;
            pix_idx++;
            set_pixel();
        end else if (mode == 1) begin
            n_rst = 1'b0;
            #1;
            chk1("arst_write", master_write, 1'b0);
            chk1("arst_busy", busy, 1'b0);
            chk32("arst_addr", master_address, 32'd0);
        end else begin
            n = 0;
            while (busy === 1'b1 && n < 300) begin
                chk1("tmo_no_bd", batch_done, 1'b0);
                tick();
                n++;
            end
            chk32("tmo_cycles", 32'(n), 32'd255);
            chk1("tmo_error", error, 1'b1);
        end
    endtask

    task automatic run_batch(input int stall_word, input int stall_n);
        for (int i = 0; i < BL; i++) begin
            serve_word((i == stall_word) ? stall_n : 0, 0);
        end
    endtask

    task automatic check_idle(input string tag);
        chk1(tag, busy, 1'b0);
        chk1("err_state", error, exp_err);
    endtask

    initial begin
        base_addr  = 32'h0000_1000;
        frame_len  = 20'd0;
        pix_idx    = 0;
        set_pixel();
        do_reset();

        // Plain batch, no stall, response one cycle after accept
        pulse_ready(1'b1);
        run_batch(-1, 0);
        check_idle("idle_after_b1");

        // Stall on the second word, stray response while still in WRITE
        do_reset();
        pulse_ready(1'b1);
        run_batch(1, 3);
        check_idle("idle_after_stall");

        // Frame of 12 words over two batches, third batch restarts at base
        do_reset();
        frame_len = 20'd12;
        for (int b = 0; b < 3; b++) begin
            pulse_ready(1'b1);
            run_batch(-1, 0);
        end
        check_idle("idle_after_frame");

        // Pending batch runs back-to-back; a third pulse overflows
        do_reset();
        frame_len = 20'd0;
        pulse_ready(1'b1);
        serve_word(0, 0);
        pulse_ready(1'b1);
        serve_word(0, 0);
        serve_word(0, 0);
        pulse_ready(1'b0);
        exp_err = 1'b1;
        chk1("overflow_error", error, 1'b1);
        for (int i = 3; i < BL; i++) serve_word(0, 0);
        run_batch(-1, 0);
        check_idle("idle_after_pending");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("no_extra_batch", master_write, 1'b0);
        end
        chk32("sb_drained", 32'(sb.size()), 32'd0);

        // Address wrap through 2^32
        base_addr = 32'hFFFF_FFF8;
        do_reset();
        pulse_ready(1'b1);
        run_batch(-1, 0);
        check_idle("idle_after_wrap");

        // Asynchronous reset while waiting for the response of word 3
        base_addr = 32'h0000_1000;
        do_reset();
        pulse_ready(1'b1);
        for (int i = 0; i < 3; i++) serve_word(0, 0);
        serve_word(0, 1);
        tick();
        do_reset();

`ifdef WRITE_MASTER_TIMEOUT_EN
        pulse_ready(1'b1);
        serve_word(0, 2);
        exp_err = 1'b1;
        check_idle("idle_after_tmo");
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
